starfield_scan: RTL and testbench
=================================

# starfield_scan

Starfield pixel generator driving an 8-bit-workshop LFSR instance directly downstream of it. Steps the LFSR once per pixel inside a rectangular star field and registers a star flag plus 2-bit brightness per pixel from the LFSR value. Adds per-frame scroll by stepping the LFSR extra times at each vsync. Handles LFSR seeding and all-zero lock-up recovery. Sits between the LFSR and the VGA colour mux.

## Interface
Parameters:
- NBITS, 16: LFSR width; must match the LFSR instance (≥ 8).
- FIELD_W, 256: star field width in pixels, from hpos = 0.
- FIELD_H, 240: star field height in lines, from vpos = 0.
- DENSITY, 8'hF8: star threshold applied to the top 8 LFSR bits.
- SPEED_W, 4: width of the `speed` input.

Ports:
- clk  input  1  pixel clock (25 MHz).
- reset  input  1  asynchronous, active-low reset.
- hpos  input  9  current pixel column.
- vpos  input  9  current pixel row.
- display_on  input  1  visible-area flag from the sync generator.
- vsync  input  1  vertical sync, active-high.
- speed  input  SPEED_W  extra LFSR steps per frame.
- lfsr  input  NBITS  current LFSR register value.
- lfsr_enable  output  1  LFSR enable (combinational from state and inputs).
- lfsr_reset  output  1  LFSR synchronous reset, active-high (combinational from state).
- star_on  output  1  registered star flag for the previous cycle's pixel.
- brightness  output  2  registered star intensity; 0 when star_on = 0.
- frame_count  output  8  frame counter.
- ready  output  1  high in RUN or ADVANCE.

## Operation
- in_field = display_on && hpos < FIELD_W && vpos < FIELD_H.
- vs_rise = vsync && !vsync_d, where vsync_d is vsync registered.
- FSM states: SEED, RUN, ADVANCE.
- SEED:
  - lfsr_reset = 1, lfsr_enable = 0.
  - A seed counter runs NBITS cycles; the LFSR shifts in one 1 per cycle, so it is all-ones at exit.
  - Then go to RUN.
- RUN:
  - lfsr_enable = in_field.
  - On vs_rise: load step counter with `speed`, go to ADVANCE.
  - If lfsr == 0 (lock-up): go to SEED. Lock-up takes priority over vs_rise.
- ADVANCE:
  - lfsr_enable = 1, decrement the step counter each cycle.
  - Return to RUN once `speed` steps are done. speed = 0 returns the next cycle with no step.
  - `speed` is sampled only at vs_rise.
- Pixel pipeline, updated every cycle:
  - star_on <= (state == RUN) && in_field && lfsr[NBITS-1:NBITS-8] >= DENSITY.
  - brightness <= star_on_next ? lfsr[1:0] : 0.
- frame_count increments on every vs_rise in any state except SEED; wraps 255 → 0.

## Timing
- Reset values: state SEED, seed and step counters 0, vsync_d 0, star_on 0, brightness 0, frame_count 0.
- Reset-derived outputs: ready 0, lfsr_reset 1, lfsr_enable 0.
- Asserting reset mid-frame or mid-ADVANCE returns to SEED immediately (asynchronous). The seed sequence then restarts from 0.
- Seeding takes exactly NBITS cycles after the first clk edge with reset high. ready rises on the following cycle.
- Pixel latency is 1 cycle: star_on and brightness for the pixel at (hpos, vpos) in cycle N are valid in cycle N+1.
- The LFSR value used for a pixel is the value before that cycle's enable edge.
- vsync asserted while in_field: the vs_rise transition still happens. Pixels during ADVANCE produce star_on = 0.
- vs_rise while in ADVANCE: ignored; the counter is not reloaded and frame_count still increments.

## Configuration
- STARFIELD_TWINKLE_EN defined: brightness <= lfsr[1:0] ^ frame_count[4:3] for star pixels. Stars change intensity every 8 frames.
- Not defined: brightness <= lfsr[1:0]; no frame dependence.
- In both cases non-star pixels output brightness 0.

## Test plan
- Reset release with NBITS=16: lfsr_reset high for exactly 16 cycles, LFSR reads 16'hFFFF, ready rises at cycle 17.
- RUN with lfsr top byte 8'hF8, in_field=1 → star_on=1 next cycle, brightness = lfsr[1:0]. Top byte 8'hF7 → star_on=0, brightness=0.
- hpos=256 (outside FIELD_W), display_on=1 → lfsr_enable=0, star_on=0; LFSR value unchanged.
- vsync rising with speed=5 → ADVANCE with lfsr_enable high exactly 5 cycles, frame_count +1. speed=0 → no enable pulse, frame_count +1.
- Force lfsr=0 in RUN → state SEED, lfsr_reset high 16 cycles, ready low, then recovery to RUN.
- STARFIELD_TWINKLE_EN defined: star with lfsr[1:0]=2'b01 at frame_count=8 → brightness 2'b00. Without the macro → 2'b01.

Source files
------------

// File: rtl/starfield_scan.sv
// Starfield pixel generator: steps a downstream LFSR once per star-field pixel and
// registers star flag and brightness per pixel. Define STARFIELD_TWINKLE_EN for frame-dependent twinkle.
module starfield_scan #(
  parameter int unsigned NBITS   = 16,
  parameter int unsigned FIELD_W = 256,
  parameter int unsigned FIELD_H = 240,
  parameter logic [7:0]  DENSITY = 8'hF8,
  parameter int unsigned SPEED_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8:0]         hpos,
  input  logic [8:0]         vpos,
  input  logic               display_on,
  input  logic               vsync,
  input  logic [SPEED_W-1:0] speed,
  input  logic [NBITS-1:0]   lfsr,
  output logic               lfsr_enable,
  output logic               lfsr_reset,
  output logic               star_on,
  output logic [1:0]         brightness,
  output logic [7:0]         frame_count,
  output logic               ready
);

  localparam int unsigned SEED_W = $clog2(NBITS);

  typedef enum logic [1:0] {
    SEED    = 2'd0,
    RUN     = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SEED_W-1:0]  seed_cnt;
  logic [SPEED_W-1:0] step_cnt;
  logic               vsync_d;
  logic               in_field;
  logic               vs_rise;
  logic               seed_done;
  logic               star_next;
  logic [1:0]         bright_next;

  assign in_field  = display_on && (32'(hpos) < FIELD_W) && (32'(vpos) < FIELD_H);
  assign vs_rise   = vsync && !vsync_d;
  assign seed_done = (seed_cnt == SEED_W'(NBITS - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SEED;
    else        state <= state_next;
  end

  // Next state; lock-up recovery wins over a frame scroll request
  always_comb begin
    state_next = state;
    unique case (state)
      SEED:    if (seed_done) state_next = RUN;
      RUN: begin
        if (lfsr == '0)   state_next = SEED;
        else if (vs_rise) state_next = ADVANCE;
      end
      ADVANCE: if (step_cnt <= SPEED_W'(1)) state_next = RUN;
      default: state_next = SEED;
    endcase
  end

  // LFSR control and status decode
  always_comb begin
    lfsr_reset  = 1'b0;
    lfsr_enable = 1'b0;
    ready       = 1'b0;
    unique case (state)
      SEED:    lfsr_reset = 1'b1;
      RUN: begin
        lfsr_enable = in_field;
        ready       = 1'b1;
      end
      ADVANCE: begin
        lfsr_enable = (step_cnt != '0);
        ready       = 1'b1;
      end
      default: lfsr_reset = 1'b1;
    endcase
  end

  // Seed and scroll-step counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_cnt <= '0;
      step_cnt <= '0;
    end else begin
      seed_cnt <= (state == SEED && !seed_done) ? seed_cnt + SEED_W'(1) : '0;
      if (state == RUN && vs_rise)
        step_cnt <= speed;
      else if (state == ADVANCE && step_cnt != '0)
        step_cnt <= step_cnt - SPEED_W'(1);
    end
  end

  assign star_next = (state == RUN) && in_field && (lfsr[NBITS-1 -: 8] >= DENSITY);

`ifdef STARFIELD_TWINKLE_EN
  assign bright_next = star_next ? (lfsr[1:0] ^ frame_count[4:3]) : 2'b00;
`else
  assign bright_next = star_next ? lfsr[1:0] : 2'b00;
`endif

  // Pixel pipeline and frame counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_d     <= 1'b0;
      star_on     <= 1'b0;
      brightness  <= 2'b00;
      frame_count <= 8'd0;
    end else begin
      vsync_d    <= vsync;
      star_on    <= star_next;
      brightness <= bright_next;
      if (vs_rise && state != SEED) frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_starfield_scan.sv
// Bench for starfield_scan: vector table, hand sequences for seeding/scroll/lock-up/twinkle,
// then random stimulus against a behavioural model; the bench also stands in for the LFSR.
module tb_starfield_scan;

  localparam int unsigned NB = 16;
`ifdef STARFIELD_TWINKLE_EN
  localparam bit TWINKLE = 1'b1;
`else
  localparam bit TWINKLE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [8:0]    hpos;
  logic [8:0]    vpos;
  logic          display_on;
  logic          vsync;
  logic [3:0]    speed;
  logic [NB-1:0] lfsr;
  logic          lfsr_enable;
  logic          lfsr_reset;
  logic          star_on;
  logic [1:0]    brightness;
  logic [7:0]    frame_count;
  logic          ready;

  starfield_scan dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .display_on  (display_on),
    .vsync       (vsync),
    .speed       (speed),
    .lfsr        (lfsr),
    .lfsr_enable (lfsr_enable),
    .lfsr_reset  (lfsr_reset),
    .star_on     (star_on),
    .brightness  (brightness),
    .frame_count (frame_count),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  typedef enum {M_SEED, M_RUN, M_ADV} mode_t;

  typedef struct {
    logic [8:0]    h;
    logic [8:0]    v;
    logic          don;
    logic [NB-1:0] l;
    logic          en;
    logic          star;
    logic [1:0]    br;
  } vec_t;

  int         n_pass = 0;
  int         n_total = 0;
  mode_t      m_mode;
  int         m_seed_left;
  int         m_steps_left;
  logic [7:0] m_fc;
  logic       m_vsync_d;
  bit         free_run;
  logic       last_en;
  logic       last_rst;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic logic [1:0] twk(input logic [1:0] b, input logic [7:0] fc);
    return b ^ (TWINKLE ? fc[4:3] : 2'b00);
  endfunction

  task automatic model_reset();
    m_mode       = M_SEED;
    m_seed_left  = NB;
    m_steps_left = 0;
    m_fc         = 8'd0;
    m_vsync_d    = 1'b0;
  endtask

  // One pixel clock: check the control outputs, predict, clock, check registered outputs, step the LFSR
  task automatic tick();
    logic       in_f;
    logic       vr;
    logic       exp_en;
    logic       exp_star;
    logic [1:0] exp_br;
    #1;
    in_f = display_on && (int'(hpos) < 256) && (int'(vpos) < 240);
    vr   = vsync && !m_vsync_d;
    case (m_mode)
      M_RUN:   exp_en = in_f;
      M_ADV:   exp_en = (m_steps_left > 0);
      default: exp_en = 1'b0;
    endcase
    check("ready", 32'(ready), 32'(m_mode != M_SEED));
    check("lfsr_reset", 32'(lfsr_reset), 32'(m_mode == M_SEED));
    check("lfsr_enable", 32'(lfsr_enable), 32'(exp_en));
    exp_star = (m_mode == M_RUN) && in_f && (lfsr[15:8] >= 8'hF8);
    exp_br   = exp_star ? twk(lfsr[1:0], m_fc) : 2'b00;
    if (vr && m_mode != M_SEED) m_fc = m_fc + 8'd1;
    case (m_mode)
      M_SEED: begin
        m_seed_left--;
        if (m_seed_left == 0) m_mode = M_RUN;
      end
      M_RUN: begin
        if (lfsr == '0) begin
          m_mode      = M_SEED;
          m_seed_left = NB;
        end else if (vr) begin
          m_mode       = M_ADV;
          m_steps_left = int'(speed);
        end
      end
      default: begin
        if (m_steps_left <= 1) m_mode = M_RUN;
        if (m_steps_left > 0) m_steps_left--;
      end
    endcase
    m_vsync_d = vsync;
    last_en   = lfsr_enable;
    last_rst  = lfsr_reset;
    @(posedge clk);
    #1;
    check("star_on", 32'(star_on), 32'(exp_star));
    check("brightness", 32'(brightness), 32'(exp_br));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    if (last_rst) lfsr = {lfsr[NB-2:0], 1'b1};
    else if (last_en && free_run) lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  endtask

  initial begin
    vec_t vecs[9];
    int   cnt;

    vecs[0] = '{h: 9'd10,  v: 9'd10,  don: 1'b1, l: 16'hF800, en: 1'b1, star: 1'b1, br: 2'd0};
    vecs[1] = '{h: 9'd10,  v: 9'd10,  don: 1'b1, l: 16'hF803, en: 1'b1, star: 1'b1, br: 2'd3};
    vecs[2] = '{h: 9'd10,  v: 9'd10,  don: 1'b1, l: 16'hF7FF, en: 1'b1, star: 1'b0, br: 2'd0};
    vecs[3] = '{h: 9'd255, v: 9'd239, don: 1'b1, l: 16'hFF02, en: 1'b1, star: 1'b1, br: 2'd2};
    vecs[4] = '{h: 9'd256, v: 9'd10,  don: 1'b1, l: 16'hFF02, en: 1'b0, star: 1'b0, br: 2'd0};
    vecs[5] = '{h: 9'd10,  v: 9'd240, don: 1'b1, l: 16'hFF02, en: 1'b0, star: 1'b0, br: 2'd0};
    vecs[6] = '{h: 9'd10,  v: 9'd10,  don: 1'b0, l: 16'hFF02, en: 1'b0, star: 1'b0, br: 2'd0};
    vecs[7] = '{h: 9'd0,   v: 9'd0,   don: 1'b1, l: 16'hF901, en: 1'b1, star: 1'b1, br: 2'd1};
    vecs[8] = '{h: 9'd511, v: 9'd511, don: 1'b1, l: 16'hFFFF, en: 1'b0, star: 1'b0, br: 2'd0};

    reset = 1'b0; hpos = '0; vpos = '0; display_on = 1'b0; vsync = 1'b0; speed = '0;
    lfsr = 16'h1234; free_run = 1'b0; last_en = 1'b0; last_rst = 1'b0;
    model_reset();
    #2;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_lfsr_reset", 32'(lfsr_reset), 32'd1);
    check("rst_lfsr_enable", 32'(lfsr_enable), 32'd0);
    check("rst_star_on", 32'(star_on), 32'd0);
    check("rst_brightness", 32'(brightness), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    model_reset();

    // Initial seeding: 16 reset cycles, ready on cycle 17
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (last_rst) cnt++;
      if (i == 15) check("seed_ready_early", 32'(ready), 32'd0);
      if (i == 16) check("seed_ready_17", 32'(ready), 32'd1);
    end
    check("seed_cycles", 32'(cnt), 32'd16);
    check("seed_lfsr_ones", 32'(lfsr), 32'hFFFF);

    // Pixel vectors in RUN
    for (int i = 0; i < 9; i++) begin
      hpos = vecs[i].h; vpos = vecs[i].v; display_on = vecs[i].don; lfsr = vecs[i].l;
      tick();
      check($sformatf("vec%0d_enable", i), 32'(last_en), 32'(vecs[i].en));
      check($sformatf("vec%0d_star", i), 32'(star_on), 32'(vecs[i].star));
      check($sformatf("vec%0d_bright", i), 32'(brightness), 32'(vecs[i].br));
    end
    display_on = 1'b0;

    // Scroll by 5, with a second vsync rise and a speed change while advancing
    speed = 4'd5; tick();
    cnt = 0;
    vsync = 1'b1; tick(); cnt += int'(last_en);
    speed = 4'd9; tick(); cnt += int'(last_en);
    vsync = 1'b0; tick(); cnt += int'(last_en);
    vsync = 1'b1; tick(); cnt += int'(last_en);
    repeat (8) begin tick(); cnt += int'(last_en); end
    check("adv5_steps", 32'(cnt), 32'd5);
    check("adv5_frames", 32'(frame_count), 32'd2);

    // speed 0: no enable pulse, frame still counts
    vsync = 1'b0; speed = 4'd0; tick();
    cnt = 0;
    vsync = 1'b1; tick(); cnt += int'(last_en);
    repeat (4) begin tick(); cnt += int'(last_en); end
    check("adv0_steps", 32'(cnt), 32'd0);
    check("adv0_frames", 32'(frame_count), 32'd3);

    // A star-valued pixel during ADVANCE is blanked
    vsync = 1'b0; tick();
    vsync = 1'b1; speed = 4'd3; display_on = 1'b1; hpos = 9'd5; vpos = 9'd5; lfsr = 16'hFF01;
    tick();
    check("pre_adv_star", 32'(star_on), 32'd1);
    tick();
    check("adv_star_blank", 32'(star_on), 32'd0);
    repeat (4) tick();
    check("post_adv_star", 32'(star_on), 32'd1);
    display_on = 1'b0; vsync = 1'b0;

    // Lock-up recovery
    tick();
    lfsr = '0;
    tick();
    check("lockup_ready", 32'(ready), 32'd0);
    cnt = 0;
    repeat (20) begin tick(); cnt += int'(last_rst); end
    check("lockup_seed_cycles", 32'(cnt), 32'd16);
    check("lockup_ready_back", 32'(ready), 32'd1);
    check("lockup_lfsr_ones", 32'(lfsr), 32'hFFFF);

    // Asynchronous reset in the middle of ADVANCE
    vsync = 1'b1; speed = 4'd10; tick();
    tick(); tick();
    reset = 1'b0;
    #1;
    check("areset_ready", 32'(ready), 32'd0);
    check("areset_lfsr_reset", 32'(lfsr_reset), 32'd1);
    check("areset_lfsr_enable", 32'(lfsr_enable), 32'd0);
    check("areset_frame_count", 32'(frame_count), 32'd0);
    #1;
    reset = 1'b1; vsync = 1'b0;
    model_reset();
    repeat (16) tick();
    check("areset_reseeded", 32'(ready), 32'd1);

    // Twinkle at frame 8
    speed = 4'd0;
    repeat (8) begin
      vsync = 1'b1; tick();
      vsync = 1'b0; tick();
    end
    check("tw_frames", 32'(frame_count), 32'd8);
    display_on = 1'b1; hpos = 9'd3; vpos = 9'd3; lfsr = 16'hF901;
    tick();
    check("tw_bright", 32'(brightness), TWINKLE ? 32'd0 : 32'd1);
    display_on = 1'b0;

    // Random traffic with a free-running LFSR and occasional lock-ups
    free_run = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      hpos       = 9'($urandom_range(0, 300));
      vpos       = 9'($urandom_range(0, 260));
      display_on = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 39) == 0) vsync = ~vsync;
      speed      = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) lfsr = '0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
